up_param: RTL and testbench
===========================

Name: up_param

Overview:
- Parametrised successor to the team's 8-bit accumulator von Neumann processor. It is a multicycle accumulator CPU with configurable data and address widths and a wider instruction set (logic ops, immediate load, conditional jumps, halt).
- It has a req/ready memory handshake, so it runs against wait-state memories as well as the zero-wait RAM model.
- It sits between the system testbench/top and a single shared instruction/data memory.

Parameters:
- DW, 16, data and instruction word width; DW >= AW+4.
- AW, 8, address width; pc and mem_addr are AW bits.
- RESET_PC, 0, pc value loaded on reset.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-low reset
- mem_req  output  1  memory transaction request
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
- mem_addr  output  AW  transaction address
- mem_wdata  output  DW  write data (acc)
- mem_rdata  input  DW  read data; sampled on the edge where mem_req and mem_ready are both 1
- mem_ready  input  1  transaction completes on a rising edge where mem_req=1 and mem_ready=1
- pc  output  AW  program counter
- ir  output  DW  instruction register
- acc  output  DW  accumulator
- halted  output  1  1 while in HALT state

Behaviour:
- Reset (reset=0, asynchronous): state=START, pc=RESET_PC, ir=0, acc=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
- A reset mid-transaction aborts it immediately; no write may complete.
- Instruction format: opcode=ir[DW-1:DW-4], operand=ir[AW-1:0]; bits between them are ignored.
- States:
  - START: the cycle after reset release; mem_req=0; next state FETCH.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On handshake edge: ir<=mem_rdata, pc<=pc+1 (mod 2^AW), next state DECODE. Otherwise stay in FETCH.
  - DECODE: mem_req=0. Non-memory opcodes execute here and go to FETCH; memory opcodes go to EXEC; HLT goes to HALT.
  - EXEC: mem_req=1, mem_addr=operand. STA: mem_we=1, mem_wdata=acc. Other memory ops: mem_we=0. On handshake edge, apply the operation and go to FETCH.
  - HALT: mem_req=0, halted=1; leave only by reset.
- Opcodes:
  - 0 NOP
  - 1 LDA: acc<=M
  - 2 STA: M<=acc
  - 3 ADD: acc<=acc+M
  - 4 SUB: acc<=acc-M
  - 5 AND
  - 6 OR
  - 7 JMP: pc<=operand
  - 8 JZ: jump if acc==0
  - 9 JN: jump if acc[DW-1]==1
  - A LDI: acc<=zero-extended operand
  - B NOT: acc<=~acc
  - F HLT
  - C, D, E: NOP
  - Memory opcodes: 1-6. All others are non-memory.
- Arithmetic: ADD and SUB wrap mod 2^DW; no carry or flags are stored. Z and N are evaluated from the current acc in DECODE.
- Handshake rules:
  - While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata stay stable.
  - Exactly one transaction completes per handshake edge.
  - mem_ready is ignored when mem_req=0.
- Latency with zero wait states:
  - Non-memory instruction: 2 cycles (FETCH, DECODE).
  - Memory instruction: 3 cycles.
  - Each wait cycle adds 1 cycle.
- pc wraps: incrementing from 2^AW-1 gives 0.
- Jump target overrides the increment; pc is written once per instruction.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release → pc=0x00, acc=0, mem_req=0 for one cycle; mem_req=1 with mem_addr=0x00 on the next cycle.
2. Zero-wait program: mem[0]=0x1010, mem[1]=0x3011, mem[2]=0x2012, mem[3]=0xF000, mem[0x10]=5, mem[0x11]=7 → mem[0x12]=12, acc=12, halted=1 at cycle 11 after START, pc=0x04.
3. Wrap arithmetic: LDA of 0xFFFF, then ADD of 0x0002 → acc=0x0001. SUB of 0x0003 from 0x0001 → acc=0xFFFE, and a following JN is taken.
4. Control flow:
   - mem[0]=0xA000 (LDI 0), mem[1]=0x8020 (JZ 0x20) → next fetch address 0x20.
   - At 0x20: JN 0x40 with acc=0 → not taken, fetch 0x21.
   - JMP 0xFF with a NOP at 0xFF → next fetch at 0x00.
5. Wait states: mem_ready held 0 for 3 cycles during STA 0x12 with acc=0x00AB → mem_req, mem_we=1, mem_addr=0x12, mem_wdata=0x00AB stable for 4 cycles; exactly one write occurs; the instruction takes 6 cycles.
6. Reset mid-STA: assert reset=0 while in EXEC with mem_ready=0 → mem_req and mem_we drop to 0 within the same cycle (asynchronously), pc=RESET_PC, target location unchanged; normal fetch from RESET_PC after release.

Source files
------------

// File: rtl/up_param.sv
// up_param -- multicycle accumulator CPU with configurable data/address width.
//
// A single shared instruction/data memory is accessed through a req/ready
// handshake, so the core tolerates any number of memory wait states.
// Every instruction is fetched (FETCH) and then decoded (DECODE).
// Memory-operand instructions take one more state (EXEC).
//
// Instruction word: opcode = ir[DW-1:DW-4], operand = ir[AW-1:0]; bits in
// between are ignored. Requires DW >= AW+4.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   mem_req    memory transaction request
//   mem_we     1 = write, 0 = read (valid while mem_req=1)
//   mem_addr   transaction address (AW bits)
//   mem_wdata  write data (acc during STA)
//   mem_rdata  read data, taken on the edge where mem_req & mem_ready
//   mem_ready  completes the pending transaction on a rising edge
//   pc         program counter
//   ir         instruction register
//   acc        accumulator
//   halted     high while in the HALT state
module up_param #(
  parameter int DW       = 16,
  parameter int AW       = 8,
  parameter int RESET_PC = 0
) (
  input  logic          clock,
  input  logic          reset,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ir,
  output logic [DW-1:0] acc,
  output logic          halted
);

  typedef enum logic [2:0] {
    st_start  = 3'd0,
    st_fetch  = 3'd1,
    st_decode = 3'd2,
    st_exec   = 3'd3,
    st_halt   = 3'd4
  } state_t;

  localparam logic [3:0] op_nop = 4'h0;
  localparam logic [3:0] op_lda = 4'h1;
  localparam logic [3:0] op_sta = 4'h2;
  localparam logic [3:0] op_add = 4'h3;
  localparam logic [3:0] op_sub = 4'h4;
  localparam logic [3:0] op_and = 4'h5;
  localparam logic [3:0] op_or  = 4'h6;
  localparam logic [3:0] op_jmp = 4'h7;
  localparam logic [3:0] op_jz  = 4'h8;
  localparam logic [3:0] op_jn  = 4'h9;
  localparam logic [3:0] op_ldi = 4'hA;
  localparam logic [3:0] op_not = 4'hB;
  localparam logic [3:0] op_hlt = 4'hF;

  state_t        state, state_nx;
  logic [AW-1:0] pc_nx;
  logic [DW-1:0] ir_nx;
  logic [DW-1:0] acc_nx;
  logic [3:0]    opcode;
  logic [AW-1:0] operand;

  assign opcode  = ir[DW-1:DW-4];
  assign operand = ir[AW-1:0];

  // Memory-operand ALU. ADD/SUB wrap modulo 2^DW; no carry or flags kept.
  function automatic logic [DW-1:0] alu(input logic [3:0]    op,
                                        input logic [DW-1:0] a,
                                        input logic [DW-1:0] m);
    logic signed [DW-1:0] sa;
    logic signed [DW-1:0] sm;
    sa = signed'(a);
    sm = signed'(m);
    case (op)
      op_lda:  alu = m;
      op_add:  alu = sa + sm;
      op_sub:  alu = sa - sm;
      op_and:  alu = a & m;
      op_or:   alu = a | m;
      default: alu = a;
    endcase
  endfunction

  // State and architectural registers. Reset is asynchronous so a pending
  // write is withdrawn the moment reset asserts (the memory outputs below
  // decode straight from state).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= st_start;
      pc    <= AW'(RESET_PC);
      ir    <= '0;
      acc   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
      acc   <= acc_nx;
    end
  end

  // Next-state and memory-interface decode. Memory outputs are purely a
  // function of registered state, so they hold steady across wait states.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    ir_nx     = ir;
    acc_nx    = acc;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = 1'b0;

    case (state)
      // START: one idle cycle after reset release
      st_start: state_nx = st_fetch;

      // FETCH: read instruction at pc, post-increment (wraps)
      st_fetch: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) begin
          ir_nx    = mem_rdata;
          pc_nx    = pc + 1'b1;
          state_nx = st_decode;
        end
      end

      // DECODE: non-memory ops finish here; jumps override the increment
      st_decode: begin
        state_nx = st_fetch;
        case (opcode)
          op_lda, op_sta, op_add,
          op_sub, op_and, op_or:  state_nx = st_exec;
          op_jmp:                 pc_nx = operand;
          op_jz:  if (acc == '0)  pc_nx = operand;
          op_jn:  if (acc[DW-1])  pc_nx = operand;
          op_ldi:                 acc_nx = DW'(operand);
          op_not:                 acc_nx = ~acc;
          op_hlt:                 state_nx = st_halt;
          default:                ;
        endcase
      end

      // EXEC: one memory operand transaction, then back to FETCH
      st_exec: begin
        mem_req  = 1'b1;
        mem_addr = operand;
        if (opcode == op_sta) begin
          mem_we    = 1'b1;
          mem_wdata = acc;
        end
        if (mem_ready) begin
          if (opcode != op_sta) acc_nx = alu(opcode, acc, mem_rdata);
          state_nx = st_fetch;
        end
      end

      // HALT: parked until reset
      st_halt: halted = 1'b1;

      default: state_nx = st_start;
    endcase
  end

endmodule

// File: tb/tb_up_param.sv
// Bench for up_param: a behavioural memory with programmable write wait
// states, and a scoreboard of expected bus transactions (fetch / operand
// read / write) filled when each program is loaded and drained as the CPU
// completes handshakes.
module tb_up_param;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic [DW-1:0] acc;
  logic          halted;

  up_param #(.DW(DW), .AW(AW), .RESET_PC(0)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .ir        (ir),
    .acc       (acc),
    .halted    (halted)
  );

  always #5 clock = ~clock;

  // Memory model; all array updates happen in this one process.
  logic [DW-1:0] mem [0:255];
  logic          pk_en   = 1'b0;
  logic          pk_clr  = 1'b0;
  logic [AW-1:0] pk_addr = '0;
  logic [DW-1:0] pk_data = '0;
  int            wr_waits = 0;
  int            wcnt     = 0;
  int            wr_cnt   = 0;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = !(mem_req && mem_we && (wcnt < wr_waits));

  always @(posedge clock) begin
    if (pk_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (pk_en) begin
      mem[pk_addr] <= pk_data;
    end
    if (!reset) begin
      wcnt <= 0;
    end else if (mem_req && mem_we) begin
      if (mem_ready) begin
        mem[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
        wcnt   <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  typedef struct {
    logic          ex;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t exp_q[$];
  logic exec_pend = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_f(input logic [AW-1:0] a);
    exp_q.push_back('{ex: 1'b0, we: 1'b0, addr: a, data: '0});
  endtask
  task automatic push_r(input logic [AW-1:0] a);
    exp_q.push_back('{ex: 1'b1, we: 1'b0, addr: a, data: '0});
  endtask
  task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{ex: 1'b1, we: 1'b1, addr: a, data: d});
  endtask

  // Advance to the next falling edge and score any handshake that the
  // following rising edge will complete.
  task automatic step();
    txn_t e;
    logic is_ex;
    logic [3:0] op;
    @(negedge clock);
    if (!reset) begin
      exec_pend = 1'b0;
    end else if (mem_req && mem_ready) begin
      is_ex = exec_pend;
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_kind", is_ex, e.ex);
        chk("sb_we", mem_we, e.we);
        chk("sb_addr", mem_addr, e.addr);
        if (e.we) chk("sb_wdata", mem_wdata, e.data);
      end
      if (!is_ex && !mem_we) begin
        op = mem_rdata[DW-1:DW-4];
        exec_pend = (op >= 4'h1) && (op <= 4'h6);
      end else begin
        exec_pend = 1'b0;
      end
    end
  endtask

  task automatic load_begin();
    reset  = 1'b0;
    pk_clr = 1'b1;
    step();
    pk_clr = 1'b0;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pk_en   = 1'b1;
    pk_addr = a;
    pk_data = d;
    step();
    pk_en   = 1'b0;
  endtask

  task automatic release_rst();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_pc", pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ir", ir, 0);
    chk("rst_halted", halted, 0);
    step();
    chk("start_req", mem_req, 1);
    chk("start_addr", mem_addr, 0);
  endtask

  task automatic run_to_halt(input int max, output int n);
    n = 0;
    while (!halted && n < max) begin
      step();
      n++;
    end
    chk("halt_reached", halted, 1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n, k, i1, i2, nwe, w0;
    logic found;

    // Zero-wait program: LDA/ADD/STA/HLT
    load_begin();
    poke(8'h00, 16'h1010);
    poke(8'h01, 16'h3011);
    poke(8'h02, 16'h2012);
    poke(8'h03, 16'hF000);
    poke(8'h10, 16'h0005);
    poke(8'h11, 16'h0007);
    push_f(8'h00); push_r(8'h10);
    push_f(8'h01); push_r(8'h11);
    push_f(8'h02); push_w(8'h12, 16'd12);
    push_f(8'h03);
    release_rst();
    run_to_halt(200, n);
    chk("p1_halt_cycles", n, 11);
    chk("p1_acc", acc, 16'd12);
    chk("p1_pc", pc, 8'h04);
    chk("p1_mem12", mem[8'h12], 16'd12);
    step(); step(); step();
    chk("p1_halt_hold", halted, 1);
    chk("p1_halt_req", mem_req, 0);
    chk("p1_halt_pc", pc, 8'h04);

    // Wrap arithmetic and a taken JN
    load_begin();
    poke(8'h00, 16'h1010);
    poke(8'h01, 16'h3011);
    poke(8'h02, 16'h2012);
    poke(8'h03, 16'h4013);
    poke(8'h04, 16'h2014);
    poke(8'h05, 16'h9030);
    poke(8'h06, 16'hF000);
    poke(8'h30, 16'h2015);
    poke(8'h31, 16'hF000);
    poke(8'h10, 16'hFFFF);
    poke(8'h11, 16'h0002);
    poke(8'h13, 16'h0003);
    push_f(8'h00); push_r(8'h10);
    push_f(8'h01); push_r(8'h11);
    push_f(8'h02); push_w(8'h12, 16'h0001);
    push_f(8'h03); push_r(8'h13);
    push_f(8'h04); push_w(8'h14, 16'hFFFE);
    push_f(8'h05);
    push_f(8'h30); push_w(8'h15, 16'hFFFE);
    push_f(8'h31);
    release_rst();
    run_to_halt(200, n);
    chk("p2_acc", acc, 16'hFFFE);
    chk("p2_pc", pc, 8'h32);
    chk("p2_add_wrap", mem[8'h12], 16'h0001);
    chk("p2_sub_wrap", mem[8'h14], 16'hFFFE);

    // Control flow, logic ops, LDI, NOT, pc wrap
    load_begin();
    poke(8'h00, 16'h1050);
    poke(8'h01, 16'h8020);
    poke(8'h02, 16'hF000);
    poke(8'h20, 16'h9040);
    poke(8'h21, 16'hAFA5);
    poke(8'h22, 16'hB000);
    poke(8'h23, 16'h5051);
    poke(8'h24, 16'h6052);
    poke(8'h25, 16'h2050);
    poke(8'h26, 16'hC000);
    poke(8'h27, 16'h70FF);
    poke(8'hFF, 16'h0000);
    poke(8'h51, 16'h0FF0);
    poke(8'h52, 16'h1003);
    push_f(8'h00); push_r(8'h50); push_f(8'h01);
    push_f(8'h20); push_f(8'h21); push_f(8'h22);
    push_f(8'h23); push_r(8'h51);
    push_f(8'h24); push_r(8'h52);
    push_f(8'h25); push_w(8'h50, 16'h1F53);
    push_f(8'h26); push_f(8'h27); push_f(8'hFF);
    push_f(8'h00); push_r(8'h50); push_f(8'h01); push_f(8'h02);
    release_rst();
    run_to_halt(300, n);
    chk("p3_acc", acc, 16'h1F53);
    chk("p3_pc", pc, 8'h03);

    // Write wait states: 3 stalled cycles on STA
    load_begin();
    poke(8'h00, 16'hA0AB);
    poke(8'h01, 16'h2012);
    poke(8'h02, 16'hF000);
    wr_waits = 3;
    w0 = wr_cnt;
    push_f(8'h00); push_f(8'h01); push_w(8'h12, 16'h00AB); push_f(8'h02);
    release_rst();
    i1 = 1; i2 = -1; nwe = 0; k = 1;
    while (!halted && k < 60) begin
      step();
      k++;
      if (mem_req && !mem_we && mem_addr == 8'h02 && i2 < 0) i2 = k;
      if (mem_req && mem_we) begin
        nwe++;
        chk("ws_addr", mem_addr, 8'h12);
        chk("ws_wdata", mem_wdata, 16'h00AB);
      end
    end
    // fetch of address 1 follows the LDI fetch (k=1) and its decode
    i1 = 3;
    chk("ws_halt", halted, 1);
    chk("ws_we_cycles", nwe, 4);
    chk("ws_instr_len", i2 - i1, 6);
    chk("ws_writes", wr_cnt - w0, 1);
    chk("ws_mem12", mem[8'h12], 16'h00AB);
    chk("ws_sb_drained", exp_q.size(), 0);

    // Reset asserted while a stalled STA is pending
    load_begin();
    poke(8'h00, 16'hA077);
    poke(8'h01, 16'h2012);
    poke(8'h02, 16'hF000);
    poke(8'h12, 16'h1234);
    wr_waits = 1000;
    push_f(8'h00); push_f(8'h01);
    release_rst();
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      step();
      k++;
      found = mem_req && mem_we;
    end
    chk("rm_in_exec", found, 1);
    w0 = wr_cnt;
    reset = 1'b0;
    #1;
    chk("rm_req_drop", mem_req, 0);
    chk("rm_we_drop", mem_we, 0);
    chk("rm_pc", pc, 0);
    chk("rm_sb_drained", exp_q.size(), 0);
    step(); step();
    chk("rm_mem12_kept", mem[8'h12], 16'h1234);
    chk("rm_no_write", wr_cnt - w0, 0);
    wr_waits = 0;
    push_f(8'h00); push_f(8'h01); push_w(8'h12, 16'h0077); push_f(8'h02);
    release_rst();
    run_to_halt(200, n);
    chk("rm_mem12_new", mem[8'h12], 16'h0077);
    chk("rm_acc", acc, 16'h0077);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
